// File: rtl/pipeline_hazard_sequencer.sv
// Front-pipeline hazard control: per-register stall/flush, PC redirect, misprediction recovery FSM
// and a registered branch-miss broadcast. Define HAZARD_STATS_EN to build the statistics counters.
module pipeline_hazard_sequencer #(
    parameter int NUM_STAGES      = 4,
    parameter int PC_WIDTH        = 32,
    parameter int BID_WIDTH       = 4,
    parameter int RECOVER_STAGE   = 2,
    parameter int RECOVERY_CYCLES = 2,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_STAGES-1:0]            hold_req,
    input  logic [NUM_STAGES-1:0]            redirect_valid,
    input  logic [NUM_STAGES*PC_WIDTH-1:0]   redirect_target,
    input  logic [NUM_STAGES*BID_WIDTH-1:0]  redirect_bid,
    input  logic [NUM_STAGES-1:0]            redirect_color,
    output logic [NUM_STAGES-1:0]            stall,
    output logic [NUM_STAGES-1:0]            flush,
    output logic                             load_pc_we,
    output logic [PC_WIDTH-1:0]              load_pc,
    output logic                             recover_busy,
    output logic                             miss_valid,
    output logic [BID_WIDTH-1:0]             miss_bid,
    output logic                             miss_color,
    input  logic [3:0]                       stat_sel,
    output logic [CNT_WIDTH-1:0]             stat_data
);

    localparam int RC_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_INIT = RC_W'(RECOVERY_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    state_t state, state_next;
    logic [RC_W-1:0] count, count_next;

    logic                  win_valid;
    logic                  win_rec;
    logic [NUM_STAGES-1:0] win_mask;
    logic [PC_WIDTH-1:0]   win_target;
    logic [BID_WIDTH-1:0]  win_bid;
    logic                  win_color;
    logic                  redir_acc;
    logic                  hold_acc;
    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] flush_c;

    // Oldest (highest-index) redirect wins; win_mask marks every register at or below it.
    always_comb begin
        win_valid  = 1'b0;
        win_rec    = 1'b0;
        win_mask   = '0;
        win_target = '0;
        win_bid    = '0;
        win_color  = 1'b0;
        redir_acc  = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (redirect_valid[k]) begin
                win_valid  = 1'b1;
                win_target = redirect_target[k*PC_WIDTH +: PC_WIDTH];
                win_bid    = redirect_bid[k*BID_WIDTH +: BID_WIDTH];
                win_color  = redirect_color[k];
                if (k >= RECOVER_STAGE) begin
                    win_rec = 1'b1;
                end
            end
        end
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            redir_acc   = redir_acc | redirect_valid[k];
            win_mask[k] = redir_acc;
        end
    end

    always_comb begin
        stall_c  = '0;
        flush_c  = '0;
        hold_acc = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            hold_acc   = hold_acc | hold_req[k];
            stall_c[k] = hold_acc;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            flush_c[k] = hold_req[k-1] & ~stall_c[k];
        end
        if (state == RECOVER) begin
            stall_c[0] = 1'b1;
            if (!stall_c[1]) begin
                flush_c[1] = 1'b1;
            end
        end
        // A redirect overrides both the hold chain and recovery for everything it squashes.
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (win_mask[k]) begin
                stall_c[k] = 1'b0;
                flush_c[k] = (k != 0);
            end
        end
    end

    assign stall        = rst_n ? stall_c : '0;
    assign flush        = rst_n ? flush_c : '0;
    assign load_pc_we   = rst_n & win_valid;
    assign load_pc      = (rst_n && win_valid) ? win_target : '0;
    assign recover_busy = (state == RECOVER);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (win_rec) begin
                    state_next = RECOVER;
                    count_next = RC_INIT;
                end
            end
            RECOVER: begin
                if (win_rec) begin
                    count_next = RC_INIT;
                end else if (count == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - RC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_valid <= 1'b0;
            miss_bid   <= '0;
            miss_color <= 1'b0;
        end else begin
            miss_valid <= win_rec;
            if (win_rec) begin
                miss_bid   <= win_bid;
                miss_color <= win_color;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt [NUM_STAGES];
    logic [CNT_WIDTH-1:0] rise_cnt;
    logic [CNT_WIDTH-1:0] rec_cnt;
    logic [CNT_WIDTH-1:0] nonrec_cnt;
    logic [CNT_WIDTH-1:0] busy_cnt;
    logic                 hold0_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value,
                                                     input logic en);
        return (en && (value != '1)) ? value + CNT_WIDTH'(1) : value;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stall_cnt[k] <= '0;
            end
            rise_cnt   <= '0;
            rec_cnt    <= '0;
            nonrec_cnt <= '0;
            busy_cnt   <= '0;
            hold0_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stall_cnt[k] <= sat_inc(stall_cnt[k], stall_c[k]);
            end
            rise_cnt   <= sat_inc(rise_cnt, hold_req[0] & ~hold0_q);
            rec_cnt    <= sat_inc(rec_cnt, win_rec);
            nonrec_cnt <= sat_inc(nonrec_cnt, win_valid & ~win_rec);
            busy_cnt   <= sat_inc(busy_cnt, state == RECOVER);
            hold0_q    <= hold_req[0];
        end
    end

    always_comb begin
        stat_data = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stat_sel == 4'(k)) begin
                stat_data = stall_cnt[k];
            end
        end
        case (stat_sel)
            4'd8:    stat_data = rise_cnt;
            4'd9:    stat_data = rec_cnt;
            4'd10:   stat_data = nonrec_cnt;
            4'd11:   stat_data = busy_cnt;
            default: ;
        endcase
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_data       = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model.
module tb_pipeline_hazard_sequencer;

    localparam int NS = 4;
    localparam int PW = 32;
    localparam int BW = 4;
    localparam int RS = 2;
    localparam int RC = 2;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    hold_req;
    logic [NS-1:0]    redirect_valid;
    logic [NS*PW-1:0] redirect_target;
    logic [NS*BW-1:0] redirect_bid;
    logic [NS-1:0]    redirect_color;
    logic [NS-1:0]    stall;
    logic [NS-1:0]    flush;
    logic             load_pc_we;
    logic [PW-1:0]    load_pc;
    logic             recover_busy;
    logic             miss_valid;
    logic [BW-1:0]    miss_bid;
    logic             miss_color;
    logic [3:0]       stat_sel;
    logic [CW-1:0]    stat_data;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(
        .NUM_STAGES(NS), .PC_WIDTH(PW), .BID_WIDTH(BW),
        .RECOVER_STAGE(RS), .RECOVERY_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold_req(hold_req), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .redirect_bid(redirect_bid),
        .redirect_color(redirect_color), .stall(stall), .flush(flush),
        .load_pc_we(load_pc_we), .load_pc(load_pc), .recover_busy(recover_busy),
        .miss_valid(miss_valid), .miss_bid(miss_bid), .miss_color(miss_color),
        .stat_sel(stat_sel), .stat_data(stat_data)
    );

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] tgt  [NS];
    logic [BW-1:0] bidv [NS];
    logic          colv [NS];
    logic [NS-1:0] cur_hr, cur_rv;
    logic          cur_rstn;
    logic [3:0]    cur_sel;

    // Model state: remaining recovery cycles, last miss broadcast and event counts.
    int            rem;
    logic          m_valid;
    logic [BW-1:0] m_bid;
    logic          m_color;
    int            stall_cnt [NS];
    int            rise_cnt, rec_cnt, nonrec_cnt, busy_cnt;
    logic          prev_h0;
    logic [NS-1:0] exp_stall, exp_flush;
    int            win;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expStat(input logic [3:0] sel);
`ifdef HAZARD_STATS_EN
        if (int'(sel) < NS) return 64'(stall_cnt[sel]);
        case (sel)
            4'd8:  return 64'(rise_cnt);
            4'd9:  return 64'(rec_cnt);
            4'd10: return 64'(nonrec_cnt);
            4'd11: return 64'(busy_cnt);
            default: ;
        endcase
`endif
        return 64'd0;
    endfunction

    task automatic resetModel();
        rem = 0; m_valid = 1'b0; m_bid = '0; m_color = 1'b0;
        for (int k = 0; k < NS; k++) stall_cnt[k] = 0;
        rise_cnt = 0; rec_cnt = 0; nonrec_cnt = 0; busy_cnt = 0; prev_h0 = 1'b0;
    endtask

    task automatic computeExpected();
        win = -1;
        for (int k = 0; k < NS; k++) if (cur_rv[k]) win = k;
        exp_flush = '0;
        for (int k = 0; k < NS; k++) exp_stall[k] = ((cur_hr >> k) != 0);
        for (int k = 1; k < NS; k++) exp_flush[k] = cur_hr[k-1] && !exp_stall[k];
        if (rem > 0) begin
            exp_stall[0] = 1'b1;
            if (!exp_stall[1]) exp_flush[1] = 1'b1;
        end
        for (int k = 0; k <= win; k++) begin
            exp_stall[k] = 1'b0;
            exp_flush[k] = (k >= 1);
        end
        if (!cur_rstn) begin
            exp_stall = '0;
            exp_flush = '0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NS-1:0] hr, input logic [NS-1:0] rv,
                                 input logic [3:0] sel);
        logic exp_we;
        rst_n = r; hold_req = hr; redirect_valid = rv; stat_sel = sel;
        for (int k = 0; k < NS; k++) begin
            redirect_target[k*PW +: PW] = tgt[k];
            redirect_bid[k*BW +: BW]    = bidv[k];
            redirect_color[k]           = colv[k];
        end
        cur_rstn = r; cur_hr = hr; cur_rv = rv; cur_sel = sel;
        #2;
        computeExpected();
        exp_we = cur_rstn && (win >= 0);
        checkOutput("stall", stall, exp_stall);
        checkOutput("flush", flush, exp_flush);
        checkOutput("load_pc_we", load_pc_we, exp_we);
        if (exp_we) checkOutput("load_pc", load_pc, tgt[win]);
        checkOutput("recover_busy", recover_busy, rem > 0);
        checkOutput("miss_valid", miss_valid, m_valid);
        if (m_valid) begin
            checkOutput("miss_bid", miss_bid, m_bid);
            checkOutput("miss_color", miss_color, m_color);
        end
        checkOutput("stat_data", stat_data, expStat(sel));
    endtask

    task automatic advance();
        if (!cur_rstn) begin
            resetModel();
        end else begin
            for (int k = 0; k < NS; k++) if (exp_stall[k]) stall_cnt[k]++;
            if (cur_hr[0] && !prev_h0) rise_cnt++;
            prev_h0 = cur_hr[0];
            if (win >= RS) rec_cnt++;
            else if (win >= 0) nonrec_cnt++;
            if (rem > 0) busy_cnt++;
            m_valid = (win >= RS);
            if (win >= RS) begin
                m_bid = bidv[win]; m_color = colv[win]; rem = RC;
            end else if (rem > 0) begin
                rem--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, '0, '0, 4'd0);
            advance();
        end
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin tgt[k] = '0; bidv[k] = '0; colv[k] = 1'b0; end
        rst_n = 1'b0; hold_req = '0; redirect_valid = '0; redirect_target = '0;
        redirect_bid = '0; redirect_color = '0; stat_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        resetModel();
        applyStimulus(1'b0, '0, '0, 4'd0);
        checkOutput("reset_busy", recover_busy, 1'b0);
        advance();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0100, '0, 4'd0);
            checkOutput("tp_hold_stall", stall, 4'b0111);
            checkOutput("tp_hold_flush", flush, 4'b1000);
            advance();
        end
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_release_stall", stall, 4'b0000);
        advance();

        tgt[1] = 32'h400;
        applyStimulus(1'b1, '0, 4'b0010, 4'd0);
        checkOutput("tp_early_pc", load_pc, 32'h400);
        checkOutput("tp_early_flush", flush, 4'b0010);
        advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_early_busy", recover_busy, 1'b0);
        checkOutput("tp_early_miss", miss_valid, 1'b0);
        advance();

        tgt[2] = 32'h800; bidv[2] = 4'd5; colv[2] = 1'b1;
        applyStimulus(1'b1, '0, 4'b0110, 4'd0);
        checkOutput("tp_mis_pc", load_pc, 32'h800);
        checkOutput("tp_mis_flush", flush, 4'b0110);
        advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_mis_valid", miss_valid, 1'b1);
        checkOutput("tp_mis_bid", miss_bid, 4'd5);
        checkOutput("tp_mis_stall0", stall[0], 1'b1);
        advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_mis_busy2", recover_busy, 1'b1);
        advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_mis_done", recover_busy, 1'b0);
        advance();

        applyStimulus(1'b1, 4'b1000, 4'b0100, 4'd0);
        checkOutput("tp_mix_stall", stall, 4'b1000);
        checkOutput("tp_mix_flush", flush, 4'b0110);
        idle(3);

        tgt[3] = 32'hC00; bidv[3] = 4'd9; colv[3] = 1'b0;
        applyStimulus(1'b1, '0, 4'b1000, 4'd0); advance();
        applyStimulus(1'b1, '0, '0, 4'd0);      advance();
        applyStimulus(1'b1, '0, 4'b1000, 4'd0); advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_reload_pulse", miss_valid, 1'b1);
        advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_reload_busy", recover_busy, 1'b1);
        advance();
        applyStimulus(1'b1, '0, 4'b1000, 4'd0); advance();
        applyStimulus(1'b0, '0, '0, 4'd0);      advance();
        applyStimulus(1'b1, '0, '0, 4'd0);
        checkOutput("tp_rst_busy", recover_busy, 1'b0);
        checkOutput("tp_rst_miss", miss_valid, 1'b0);
        advance();

        applyStimulus(1'b0, '0, '0, 4'd0); advance();
        applyStimulus(1'b1, 4'b0001, '0, 4'd0); advance();
        applyStimulus(1'b1, 4'b0001, '0, 4'd0); advance();
        applyStimulus(1'b1, 4'b0000, '0, 4'd0); advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0001, '0, 4'd0); advance();
        end
        applyStimulus(1'b1, '0, '0, 4'd0);
`ifdef HAZARD_STATS_EN
        checkOutput("tp_stat_stall0", stat_data, 64'd5);
`else
        checkOutput("tp_stat_stall0", stat_data, 64'd0);
`endif
        advance();
        applyStimulus(1'b1, '0, '0, 4'd8);
`ifdef HAZARD_STATS_EN
        checkOutput("tp_stat_rise", stat_data, 64'd2);
`else
        checkOutput("tp_stat_rise", stat_data, 64'd0);
`endif
        advance();

        for (int i = 0; i < 500; i++) begin
            logic [NS-1:0] hr, rv;
            for (int k = 0; k < NS; k++) begin
                tgt[k]  = $urandom;
                bidv[k] = BW'($urandom);
                colv[k] = 1'($urandom_range(0, 1));
            end
            hr = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            rv = '0;
            for (int k = 0; k < NS; k++) if ($urandom_range(0, 5) == 0) rv[k] = 1'b1;
            applyStimulus(($urandom_range(0, 60) != 0), hr, rv, 4'($urandom_range(0, 15)));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Parametrised successor to the fixed IF/DEC/ISSUE hazard controller. It takes per-stage hold requests and per-stage redirect requests from an N-stage front pipeline and produces per-register stall/flush controls and a PC load. It adds a multi-cycle misprediction recovery state machine, which holds fetch while the rename checkpoint restores, and a registered branch-miss broadcast. It sits beside the front pipeline; register k is the register feeding stage k, and register 0 is the PC register.

Parameters:
NUM_STAGES, 4, number of pipeline registers/stages (min 2).
PC_WIDTH, 32, PC width.
BID_WIDTH, 4, branch ID width.
RECOVER_STAGE, 2, lowest stage index whose redirect is a misprediction needing recovery.
RECOVERY_CYCLES, 2, cycles fetch is held after a recovering redirect (min 1).
CNT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
hold_req  in  NUM_STAGES  stage k cannot advance its instruction this cycle
redirect_valid  in  NUM_STAGES  stage k requests a PC redirect
redirect_target  in  NUM_STAGES*PC_WIDTH  target for stage k, packed (k*PC_WIDTH)
redirect_bid  in  NUM_STAGES*BID_WIDTH  branch ID for stage k
redirect_color  in  NUM_STAGES  color bit for stage k
stall  out  NUM_STAGES  hold register k
flush  out  NUM_STAGES  load bubble into register k (flush[0] is always 0)
load_pc_we  out  1  load PC
load_pc  out  PC_WIDTH  new PC
recover_busy  out  1  recovery FSM not IDLE
miss_valid  out  1  registered branch-miss pulse
miss_bid  out  BID_WIDTH  ID of the miss
miss_color  out  1  color of the miss
stat_sel  in  4  statistics select
stat_data  out  CNT_WIDTH  statistics readout

Behaviour:
- Reset: all outputs 0; FSM IDLE; recovery counter 0; miss registers 0.
- Redirect winner r = highest index with redirect_valid set. The oldest instruction wins, so a late mispredict beats an early taken prediction. No redirect means no winner.
- Stall/flush, combinational, with priority from lowest to highest:
  1. Base rule: stall[k] = OR of hold_req[j] for j >= k. flush[k] (k >= 1) = hold_req[k-1] & ~stall[k], which inserts a bubble at the stall boundary.
  2. Recovery active (FSM RECOVER): stall[0] = 1; flush[1] = 1 unless stall[1].
  3. Winner r exists: for k <= r, stall[k] = 0; flush[k] = 1 for 1 <= k <= r; load_pc_we = 1; load_pc = target[r]. Registers above r keep the base rule.
- Redirect overrides recovery. A new winner during RECOVER sets load_pc_we and flushes as above.
- Recovery FSM states: IDLE and RECOVER.
  - IDLE -> RECOVER when winner r >= RECOVER_STAGE; counter loads RECOVERY_CYCLES-1.
  - In RECOVER, a new winner r >= RECOVER_STAGE reloads the counter to RECOVERY_CYCLES-1 and stays in RECOVER. Otherwise the counter decrements, and the FSM goes RECOVER -> IDLE when the counter is 0.
  - recover_busy = (state == RECOVER).
- Miss broadcast: one cycle after a winner r >= RECOVER_STAGE, miss_valid = 1 and miss_bid/miss_color hold that winner's values. miss_valid lasts exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Redirects below RECOVER_STAGE: only PC load and flush; no FSM entry, no miss pulse.
- Reset mid-recovery: FSM goes to IDLE and the pulse is cleared at the next edge.
- Simultaneous hold_req and redirect at the same stage: the redirect wins for k <= r.

Optional Feature:
Macro HAZARD_STATS_EN.
- With the macro: saturating CNT_WIDTH counters, cleared on reset.
  - stat_sel 0..NUM_STAGES-1: cycles with stall[k] = 1.
  - stat_sel 8: rising edges of hold_req[0] (new fetch misses, not miss cycles).
  - stat_sel 9: recovering redirects.
  - stat_sel 10: non-recovering redirects.
  - stat_sel 11: RECOVER cycles.
  - Any other stat_sel: stat_data = 0.
- Without the macro: no counters; stat_data tied to 0.

Test Plan:
- hold_req = 4'b0100 for 3 cycles -> stall = 4'b0111, flush = 4'b1000 each cycle. Then hold_req = 0 -> stall = 0, flush = 0.
- redirect_valid = 4'b0010, target 0x400 -> load_pc_we = 1, load_pc = 0x400, flush = 4'b0010; recover_busy stays 0; no miss pulse.
- redirect_valid = 4'b0110 with target[2] = 0x800, bid[2] = 5, color 1 -> load_pc = 0x800, flush = 4'b0110. Next cycle: miss_valid = 1, miss_bid = 5, miss_color = 1, recover_busy = 1, stall[0] = 1 for 2 cycles, then IDLE.
- hold_req = 4'b1000 plus redirect at stage 2 -> stall = 4'b1000, flush = 4'b0110, load_pc_we = 1.
- Second stage-3 redirect in the 2nd RECOVER cycle -> counter reloads; recover_busy high 2 more cycles; two miss pulses. rst_n low mid-RECOVER -> all outputs 0 the next cycle.
- HAZARD_STATS_EN: 5 stage-0 stall cycles, 2 hold_req[0] rising edges -> stat_sel 0 reads 5, stat_sel 8 reads 2.
